// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared types and constants for the iterative multiply/divide unit.
//   - mdu_op_e    : RV32M funct3 operation encoding
//   - mdu_state_e : control FSM states
//   - mdu_most_neg: most-negative two's-complement value for a given width
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Widest supported operand; the helper below returns values of this width
    // and callers keep the low XLEN bits.
    localparam int unsigned MDU_XLEN_MAX = 64;

    function automatic logic [MDU_XLEN_MAX-1:0] mdu_most_neg(input int unsigned xlen);
        logic [MDU_XLEN_MAX-1:0] val;
        val            = '0;
        val[xlen-1]    = 1'b1;
        return val;
    endfunction

endpackage

// File: rtl/mdu_iterative_div_step.sv
// -----------------------------------------------------------------------------
// mdu_iterative_div_step
//   One combinational restoring-division iteration. The partial remainder is
//   shifted left with the next dividend bit, the divisor is trial-subtracted,
//   and the difference is kept only when it is non-negative.
//
//   Ports:
//     rem_i  [XLEN-1:0]  partial remainder before this iteration
//     bit_i              next dividend bit (MSB first)
//     div_i  [XLEN-1:0]  divisor magnitude
//     rem_o  [XLEN-1:0]  partial remainder after this iteration
//     q_o                quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module mdu_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Two guard bits: the shifted remainder can reach XLEN+1 bits and the
    // top bit of diff is the borrow that decides the quotient bit.
    assign shifted = {rem_i, bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, div_i};
    assign q_o     = ~diff[XLEN+1];
    assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
//   Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiplier and
//   restoring divider sharing one 2*XLEN working register, one bit per clock.
//   Signed operations run on magnitudes and the result is negated at the
//   output when its sign flag is set.
//
//   Optional feature (macro MDU_EARLY_OUT_EN): divide-by-zero, signed
//   overflow and any operation with b == 0 complete on the accept edge.
//   Results are identical with or without it; only latency differs.
//
//   Ports:
//     clk_i, rst_ni         clock, asynchronous active-low reset
//     valid_i / ready_o     request handshake (ready_o high only in IDLE)
//     op_i [2:0]            RV32M funct3
//     a_num_i, b_num_i      rs1 / rs2 operands, sampled on the accept edge
//     flush_i               abort in-flight operation, blocks acceptance
//     valid_o / ready_i     result handshake (valid_o high only in DONE)
//     c_num_o               result
//     zero_o, negative_o    status flags, qualified by valid_o
// -----------------------------------------------------------------------------
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_num_i,
    input  logic [XLEN-1:0] b_num_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] c_num_o,
    output logic            zero_o,
    output logic            negative_o
);

    // Working register layout:
    //   multiply: [2X-1:X] accumulating product high half, [X-1:0] multiplier
    //             (shifted out LSB first, product low half shifts in behind it)
    //   divide  : [2X-1:X] partial remainder, [X-1:0] dividend shifting out
    //             MSB first with quotient bits shifting in at the LSB
    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    mdu_op_e           op_q,    op_d;
    logic              neg_q,   neg_d;
    logic [2*XLEN-1:0] prod_q,  prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude

    // ---------------------------------------------------------------- accept
    mdu_op_e         op_in;
    logic            a_signed, b_signed;
    logic            sa, sb, b_zero, is_div_in, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    assign op_in     = mdu_op_e'(op_i);
    assign is_div_in = op_i[2];
    assign a_signed  = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed  = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign sa        = a_signed & a_num_i[XLEN-1];
    assign sb        = b_signed & b_num_i[XLEN-1];
    assign mag_a     = sa ? -a_num_i : a_num_i;
    assign mag_b     = sb ? -b_num_i : b_num_i;
    assign b_zero    = (b_num_i == '0);

    // Result sign: products and quotients take sa^sb, remainders take the
    // dividend sign. A divide-by-zero quotient must stay all ones, so its
    // sign flag is suppressed. MUL runs unsigned: its low half is the same.
    always_comb begin
        if (!is_div_in)      neg_in = sa ^ sb;
        else if (op_i[1])    neg_in = sa;
        else                 neg_in = (sa ^ sb) & ~b_zero;
    end

`ifdef MDU_EARLY_OUT_EN
    localparam logic [MDU_XLEN_MAX-1:0] MOST_NEG_W = mdu_most_neg(XLEN);
    localparam logic [XLEN-1:0]         MOST_NEG   = MOST_NEG_W[XLEN-1:0];

    logic ovf_in;
    assign ovf_in = (op_in inside {OP_DIV, OP_REM}) &&
                    (a_num_i == MOST_NEG) && (b_num_i == '1);
`endif

    // ------------------------------------------------------------ iterations
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN-1:0]   div_rem;
    logic              div_q;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (prod_q[2*XLEN-1:XLEN]),
        .bit_i (prod_q[XLEN-1]),
        .div_i (mcand_q),
        .rem_o (div_rem),
        .q_o   (div_q)
    );

    assign div_next = {div_rem, prod_q[XLEN-2:0], div_q};

    // -------------------------------------------------------- next state
    // NOTE: every _d signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(XLEN - 1);
                    op_d    = op_in;
                    neg_d   = neg_in;
                    if (is_div_in) begin
                        prod_d  = {{XLEN{1'b0}}, mag_a};
                        mcand_d = mag_b;
                    end else begin
                        prod_d  = {{XLEN{1'b0}}, mag_b};
                        mcand_d = mag_a;
                    end
`ifdef MDU_EARLY_OUT_EN
                    // Preload the values the full iteration would have
                    // produced; the normal output sign correction finishes.
                    if (b_zero || ovf_in) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        if (!is_div_in)  prod_d = '0;
                        else if (ovf_in) prod_d = {{XLEN{1'b0}}, MOST_NEG};
                        else             prod_d = {mag_a, {XLEN{1'b1}}};
                    end
`endif
                end
            end

            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                if (flush_i || ready_i) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    // NOTE: datapath registers are reset along with control, so c_num_o and
    // the flags read zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    // -------------------------------------------------------------- outputs
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quo_fix  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

    always_comb begin
        c_num_o = '0;
        unique case (op_q)
            OP_MUL:                       c_num_o = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: c_num_o = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              c_num_o = quo_fix;
            OP_REM, OP_REMU:              c_num_o = rem_fix;
            default:                      c_num_o = '0;
        endcase
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign valid_o    = (state_q == ST_DONE);
    assign zero_o     = valid_o & (c_num_o == '0);
    assign negative_o = valid_o & c_num_o[XLEN-1];

endmodule
